// File: rtl/traffic_seq_ctrl.sv
// Traffic-light sequencing engine: timed red/green/yellow cycling, flashing red/yellow
// modes and profile-selected timing sets, with registered lamp and status outputs.
module traffic_seq_ctrl #(
    parameter int unsigned TICK_DIV    = 16,
    parameter int unsigned BLINK_TICKS = 2
) (
    input  logic        pclk,
    input  logic        preset,
    input  logic        mod_en,
    input  logic        blink_yellow,
    input  logic        blink_red,
    input  logic        profile,
    input  logic [31:0] timer_0,
    input  logic [31:0] timer_1,
    output logic        lamp_red,
    output logic        lamp_yellow,
    output logic        lamp_green,
    output logic [1:0]  state,
    output logic        blink_active,
    output logic        phase_done
);

    localparam int unsigned PW = $clog2(TICK_DIV);
    localparam int unsigned BW = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;

    typedef enum logic [2:0] {
        S_OFF,
        S_RED,
        S_GREEN,
        S_YELLOW,
        S_FLASH_R,
        S_FLASH_Y
    } fsm_t;

    fsm_t          fsm_q, fsm_d;
    logic [PW-1:0] presc_q, presc_d;
    logic [11:0]   phase_cnt_q, phase_cnt_d;
    logic [BW-1:0] blink_cnt_q, blink_cnt_d;
    logic          lamp_red_q, lamp_red_d;
    logic          lamp_yellow_q, lamp_yellow_d;
    logic          lamp_green_q, lamp_green_d;
    logic [1:0]    state_q, state_d;
    logic          blink_active_q, blink_active_d;
    logic          phase_done_q, phase_done_d;

    logic          tick;
    logic          phase_end;
    logic          entering;
    logic          blink_toggle;
    logic [31:0]   tsel;
    logic [11:0]   g2y, r2g, y2r;

    function automatic logic is_normal(input fsm_t s);
        return (s == S_RED) || (s == S_GREEN) || (s == S_YELLOW);
    endfunction

    function automatic logic [11:0] at_least_one(input logic [11:0] v);
        return (v == 12'd0) ? 12'd1 : v;
    endfunction

    always_comb begin
        tick      = (fsm_q != S_OFF) && (presc_q == PW'(TICK_DIV - 1));
        phase_end = tick && (phase_cnt_q == 12'd1);
        tsel      = profile ? timer_1 : timer_0;
        g2y       = tsel[31:20];
        r2g       = tsel[19:8];
        y2r       = {4'd0, tsel[7:0]};

        fsm_d = fsm_q;
        if (!mod_en) begin
            fsm_d = S_OFF;
        end else if (blink_red) begin
            fsm_d = S_FLASH_R;
        end else if (blink_yellow) begin
            fsm_d = S_FLASH_Y;
        end else begin
            case (fsm_q)
                S_OFF, S_FLASH_R, S_FLASH_Y: fsm_d = S_RED;
                S_RED:    if (phase_end) fsm_d = S_GREEN;
                S_GREEN:  if (phase_end) fsm_d = S_YELLOW;
                S_YELLOW: if (phase_end) fsm_d = S_RED;
                default:  fsm_d = S_OFF;
            endcase
        end
        entering = (fsm_d != fsm_q);

        // Any state change restarts the prescaler so every phase begins on a tick boundary.
        if (entering || (fsm_q == S_OFF) || tick) begin
            presc_d = '0;
        end else begin
            presc_d = presc_q + 1'b1;
        end

        phase_cnt_d = phase_cnt_q;
        if (entering) begin
            case (fsm_d)
                S_RED:    phase_cnt_d = at_least_one(r2g);
                S_GREEN:  phase_cnt_d = at_least_one(g2y);
                S_YELLOW: phase_cnt_d = at_least_one(y2r);
                default:  phase_cnt_d = phase_cnt_q;
            endcase
        end else if (tick && is_normal(fsm_q) && (phase_cnt_q != 12'd1)) begin
            phase_cnt_d = phase_cnt_q - 12'd1;
        end

        blink_toggle = 1'b0;
        blink_cnt_d  = blink_cnt_q;
        if (entering) begin
            blink_cnt_d = '0;
        end else if (tick) begin
            if (blink_cnt_q == BW'(BLINK_TICKS - 1)) begin
                blink_cnt_d  = '0;
                blink_toggle = 1'b1;
            end else begin
                blink_cnt_d = blink_cnt_q + 1'b1;
            end
        end

        lamp_red_d     = 1'b0;
        lamp_yellow_d  = 1'b0;
        lamp_green_d   = 1'b0;
        state_d        = 2'b00;
        blink_active_d = 1'b0;
        case (fsm_d)
            S_RED: begin
                lamp_red_d = 1'b1;
                state_d    = 2'b01;
            end
            S_GREEN: begin
                lamp_green_d = 1'b1;
                state_d      = 2'b10;
            end
            S_YELLOW: begin
                lamp_yellow_d = 1'b1;
                state_d       = 2'b11;
            end
            S_FLASH_R: begin
                lamp_red_d     = entering ? 1'b1 : (lamp_red_q ^ blink_toggle);
                state_d        = 2'b01;
                blink_active_d = 1'b1;
            end
            S_FLASH_Y: begin
                lamp_yellow_d  = entering ? 1'b1 : (lamp_yellow_q ^ blink_toggle);
                state_d        = 2'b11;
                blink_active_d = 1'b1;
            end
            default: state_d = 2'b00;
        endcase

        phase_done_d = entering && is_normal(fsm_q) && is_normal(fsm_d);
    end

    always_ff @(posedge pclk) begin
        if (preset) begin
            fsm_q          <= S_OFF;
            presc_q        <= '0;
            phase_cnt_q    <= '0;
            blink_cnt_q    <= '0;
            lamp_red_q     <= 1'b0;
            lamp_yellow_q  <= 1'b0;
            lamp_green_q   <= 1'b0;
            state_q        <= 2'b00;
            blink_active_q <= 1'b0;
            phase_done_q   <= 1'b0;
        end else begin
            fsm_q          <= fsm_d;
            presc_q        <= presc_d;
            phase_cnt_q    <= phase_cnt_d;
            blink_cnt_q    <= blink_cnt_d;
            lamp_red_q     <= lamp_red_d;
            lamp_yellow_q  <= lamp_yellow_d;
            lamp_green_q   <= lamp_green_d;
            state_q        <= state_d;
            blink_active_q <= blink_active_d;
            phase_done_q   <= phase_done_d;
        end
    end

    assign lamp_red     = lamp_red_q;
    assign lamp_yellow  = lamp_yellow_q;
    assign lamp_green   = lamp_green_q;
    assign state        = state_q;
    assign blink_active = blink_active_q;
    assign phase_done   = phase_done_q;

endmodule

// File: tb/tb_traffic_seq_ctrl.sv
// Bench for traffic_seq_ctrl: directed scenarios plus random control changes, checked each
// cycle against a phase-duration model through an expected-output queue.
module tb_traffic_seq_ctrl;

    localparam int TD = 4;
    localparam int BT = 2;

    logic        pclk = 1'b0;
    logic        preset;
    logic        mod_en;
    logic        blink_yellow;
    logic        blink_red;
    logic        profile;
    logic [31:0] timer_0;
    logic [31:0] timer_1;
    logic        lamp_red;
    logic        lamp_yellow;
    logic        lamp_green;
    logic [1:0]  state;
    logic        blink_active;
    logic        phase_done;

    always #5 pclk = ~pclk;

    traffic_seq_ctrl #(
        .TICK_DIV   (TD),
        .BLINK_TICKS(BT)
    ) dut (
        .pclk        (pclk),
        .preset      (preset),
        .mod_en      (mod_en),
        .blink_yellow(blink_yellow),
        .blink_red   (blink_red),
        .profile     (profile),
        .timer_0     (timer_0),
        .timer_1     (timer_1),
        .lamp_red    (lamp_red),
        .lamp_yellow (lamp_yellow),
        .lamp_green  (lamp_green),
        .state       (state),
        .blink_active(blink_active),
        .phase_done  (phase_done)
    );

    // Model modes: 0 off, 1 red, 2 green, 3 yellow, 4 flashing red, 5 flashing yellow.
    logic [6:0] exp_q[$];
    int total = 0;
    int bad   = 0;
    int cyc_n = 0;
    int m_mode = 0;
    int m_rem = 0;
    int m_elapsed = 0;
    bit m_pd = 0;

    function automatic int phase_cycles(input int mode, input logic [31:0] t);
        int n;
        case (mode)
            1:       n = int'(t[19:8]);
            2:       n = int'(t[31:20]);
            default: n = int'(t[7:0]);
        endcase
        if (n == 0) n = 1;
        return n * TD;
    endfunction

    task automatic step();
        int nxt;
        bit on, lr, ly, lg;
        logic [1:0] st;
        if (preset) begin
            m_mode = 0; m_pd = 0; m_rem = 0; m_elapsed = 0;
        end else begin
            if (!mod_en)                    nxt = 0;
            else if (blink_red)             nxt = 4;
            else if (blink_yellow)          nxt = 5;
            else if (m_mode == 0 || m_mode >= 4) nxt = 1;
            else if (m_rem == 1)            nxt = (m_mode == 3) ? 1 : m_mode + 1;
            else                            nxt = m_mode;
            if (nxt != m_mode) begin
                m_pd = (m_mode >= 1 && m_mode <= 3 && nxt >= 1 && nxt <= 3);
                m_mode = nxt;
                m_elapsed = 0;
                if (nxt >= 1 && nxt <= 3) m_rem = phase_cycles(nxt, profile ? timer_1 : timer_0);
            end else begin
                m_pd = 0;
                m_rem--;
                m_elapsed++;
            end
        end
        on = ((m_elapsed / (BT * TD)) % 2) == 0;
        lr = (m_mode == 1) || (m_mode == 4 && on);
        ly = (m_mode == 3) || (m_mode == 5 && on);
        lg = (m_mode == 2);
        case (m_mode)
            1, 4:    st = 2'b01;
            2:       st = 2'b10;
            3, 5:    st = 2'b11;
            default: st = 2'b00;
        endcase
        exp_q.push_back({lr, ly, lg, st, (m_mode >= 4), m_pd});
        @(negedge pclk);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic wait_mode(input int m);
        for (int i = 0; i < 600 && m_mode != m; i++) step();
    endtask

    logic [6:0] mon_exp, mon_act;
    initial begin
        forever begin
            @(posedge pclk);
            #1;
            cyc_n++;
            if (exp_q.size() > 0) begin
                mon_exp = exp_q.pop_front();
                mon_act = {lamp_red, lamp_yellow, lamp_green, state, blink_active, phase_done};
                total++;
                if (mon_act !== mon_exp) begin
                    bad++;
                    $display("FAIL outs cyc=%0d {r,y,g,state,blink,pd} got=%b exp=%b",
                             cyc_n, mon_act, mon_exp);
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        preset = 1'b1; mod_en = 1'b0; blink_yellow = 1'b0; blink_red = 1'b0;
        profile = 1'b0; timer_0 = '0; timer_1 = '0;
        @(negedge pclk);
        run(2);
        preset = 1'b0; mod_en = 1'b1; timer_0 = 32'h0030_2005;
        run(220);

        timer_0 = 32'h0000_0000;
        run(40);

        timer_0 = 32'h0030_2005;
        wait_mode(2);
        run(3);
        profile = 1'b1; timer_1 = 32'h0010_1002;
        run(120);

        wait_mode(1);
        run(3);
        blink_yellow = 1'b1;
        run(40);
        blink_red = 1'b1;
        run(20);
        blink_red = 1'b0; blink_yellow = 1'b0;
        run(90);

        wait_mode(3);
        run(1);
        mod_en = 1'b0;
        run(5);
        mod_en = 1'b1;
        run(150);

        wait_mode(2);
        run(2);
        preset = 1'b1;
        run(1);
        preset = 1'b0;
        run(20);

        for (int i = 0; i < 5000; i++) begin
            if ($urandom_range(0, 39) == 0) begin
                case ($urandom_range(0, 6))
                    0: mod_en = ($urandom_range(0, 7) != 0);
                    1: blink_red = ($urandom_range(0, 5) == 0);
                    2: blink_yellow = ($urandom_range(0, 3) == 0);
                    3: profile = ~profile;
                    4: timer_0 = {12'($urandom_range(0, 5)), 12'($urandom_range(0, 5)),
                                  8'($urandom_range(0, 5))};
                    5: timer_1 = {12'($urandom_range(0, 5)), 12'($urandom_range(0, 5)),
                                  8'($urandom_range(0, 5))};
                    default: begin
                        preset = 1'b1;
                        step();
                        preset = 1'b0;
                    end
                endcase
            end
            step();
        end

        repeat (3) @(posedge pclk);
        #2;
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL drain: pending=%0d required=0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
